// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: packs {start, address, length, payload} into an
// MSB-first bit stream on an idle-high line, with a guaranteed idle gap between frames.
module ser_frame_tx #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 4,
  parameter int PAY_W  = 15,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [PAY_W-1:0]  in_data,
  output logic              SerOut,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAX_AL  = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int MAX_PG  = (PAY_W > GAP) ? PAY_W : GAP;
  localparam int MAX_CNT = (MAX_AL > MAX_PG) ? MAX_AL : MAX_PG;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int SH_W    = ADDR_W + LEN_W + PAY_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] bitCnt, nextCnt;
  logic [SH_W-1:0]  shiftReg;
  logic [LEN_W-1:0] lenReg;
  logic             lineBit;
  logic             lastBit;
  logic             loadPkt;
  logic             shiftEn;
  logic [PAY_W-1:0] alignedData;

  assign in_ready = (state == S_IDLE);

  // Left-align the payload so bit L-1 lands at the top; unused upper bits fall off.
  assign alignedData = in_data << (LEN_W'(PAY_W) - in_len);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    nextCnt   = bitCnt;
    lineBit   = 1'b1;
    lastBit   = 1'b0;
    loadPkt   = 1'b0;
    shiftEn   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          loadPkt   = 1'b1;
          nextState = S_START;
        end
      end
      S_START: begin
        lineBit   = 1'b0;
        nextState = S_ADDR;
        nextCnt   = CNT_W'(ADDR_W);
      end
      S_ADDR: begin
        lineBit = shiftReg[SH_W-1];
        shiftEn = 1'b1;
        if (bitCnt == CNT_W'(1)) begin
          nextState = S_LEN;
          nextCnt   = CNT_W'(LEN_W);
        end else begin
          nextCnt = bitCnt - CNT_W'(1);
        end
      end
      S_LEN: begin
        lineBit = shiftReg[SH_W-1];
        shiftEn = 1'b1;
        if (bitCnt == CNT_W'(1)) begin
          if (lenReg == '0) begin
            lastBit   = 1'b1;
            nextState = S_GAP;
            nextCnt   = CNT_W'(GAP);
          end else begin
            nextState = S_DATA;
            nextCnt   = CNT_W'(lenReg);
          end
        end else begin
          nextCnt = bitCnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        lineBit = shiftReg[SH_W-1];
        shiftEn = 1'b1;
        if (bitCnt == CNT_W'(1)) begin
          lastBit   = 1'b1;
          nextState = S_GAP;
          nextCnt   = CNT_W'(GAP);
        end else begin
          nextCnt = bitCnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (bitCnt == CNT_W'(1)) begin
          nextState = S_IDLE;
          nextCnt   = '0;
        end else begin
          nextCnt = bitCnt - CNT_W'(1);
        end
      end
      default: nextState = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // Line outputs are registered one cycle behind the state that produced them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      lenReg     <= '0;
      SerOut     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nextState;
      bitCnt     <= nextCnt;
      SerOut     <= lineBit;
      busy       <= (state != S_IDLE);
      frame_done <= lastBit;
      if (loadPkt) begin
        shiftReg <= {in_addr, in_len, alignedData};
        lenReg   <= in_len;
      end else if (shiftEn) begin
        shiftReg <= shiftReg << 1;
      end
    end
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Self-checking bench for ser_frame_tx: a line monitor rebuilds each frame and
// compares it against a scoreboard queue of expected frames.
module tb_ser_frame_tx;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 4;
  localparam int PAY_W  = 15;
  localparam int GAP    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic [PAY_W-1:0]  in_data = '0;
  logic              SerOut;
  logic              busy;
  logic              frame_done;

  ser_frame_tx #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PAY_W(PAY_W), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_len    (in_len),
    .in_data   (in_data),
    .SerOut    (SerOut),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  len;
    logic [14:0] data;
    logic [31:0] frame;
    int          nbits;
  } vec_t;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   framesSeen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Line monitor: detects a start bit, decodes the length field, collects the frame.
  initial begin : monitor
    logic [31:0] val;
    int          n;
    int          lenSeen;
    bit          collecting;
    bit          done;
    exp_t        e;
    collecting = 0;
    val = '0;
    n = 0;
    lenSeen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        collecting = 0;
      end else if (!collecting) begin
        check("idle frame_done", frame_done, 0);
        if (SerOut == 1'b0) begin
          collecting = 1;
          val = '0;
          n = 1;
          lenSeen = 0;
        end
      end else begin
        val = {val[30:0], SerOut};
        n++;
        if (n == 7) lenSeen = int'(val[3:0]);
        done = (n >= 7) && (n == 7 + lenSeen);
        check("frame_done position", frame_done, done);
        if (done) begin
          collecting = 0;
          framesSeen++;
          if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected frame: got %0h", val);
          end else begin
            e = sbQ.pop_front();
            check("frame bits", val, e.frame);
            check("frame length", n, e.nbits);
          end
        end
      end
    end
  end

  task automatic sendPkt(input logic [1:0] a, input logic [3:0] l, input logic [14:0] d,
                         input logic [31:0] fr, input int nb);
    int   t;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_len   = l;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      expire("handshake");
      in_valid = 1'b0;
    end else begin
      e.frame = fr;
      e.nbits = nb;
      sbQ.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("in_ready after accept", in_ready, 0);
    end
  endtask

  task automatic finishFrame(input string tag);
    int t;
    t = 0;
    while (frame_done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (frame_done !== 1'b1) begin
      expire(tag);
    end else begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (busy && t < 50);
      check({tag, " busy fall after frame_done"}, t, GAP + 1);
    end
  endtask

  initial begin : main
    vec_t vecs[3];
    int   t;
    int   ones;
    int   readyCnt;
    int   zeros;
    exp_t e;

    vecs[0] = '{2'b01, 4'd6,  15'h001F, 32'h0000_059F, 13};
    vecs[1] = '{2'b11, 4'd0,  15'h7FFF, 32'h0000_0030, 7};
    vecs[2] = '{2'b10, 4'd15, 15'h5555, 32'h0017_D555, 22};

    #12;
    check("reset SerOut", SerOut, 1);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      sendPkt(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].frame, vecs[i].nbits);
      finishFrame($sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // Back-to-back: valid held high across two packets.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = 2'b00;
    in_len   = 4'd1;
    in_data  = 15'h0001;
    e.frame = 32'h03;  e.nbits = 8; sbQ.push_back(e);
    e.frame = 32'h4A;  e.nbits = 9; sbQ.push_back(e);
    @(posedge clk); #1;
    in_addr = 2'b01;
    in_len  = 4'd2;
    in_data = 15'h0002;
    check("b2b in_ready one cycle pkt1", in_ready, 0);
    t = 0;
    while (frame_done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (frame_done !== 1'b1) expire("b2b frame1 done");
    ones = 0;
    readyCnt = 0;
    t = 0;
    do begin
      @(negedge clk);
      if (SerOut) ones++;
      if (in_ready) readyCnt++;
      t++;
    end while (SerOut && t < 50);
    in_valid = 1'b0;
    check("b2b idle ones between frames", ones, GAP + 1);
    check("b2b in_ready cycles pkt2", readyCnt, 1);
    finishFrame("b2b frame2");
    repeat (2) @(negedge clk);

    // A packet pulsed during DATA must be ignored.
    sendPkt(2'b10, 4'd5, 15'h7FF6, 32'h4B6, 12);
    repeat (7) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_addr  = 2'b01;
    in_len   = 4'd3;
    in_data  = 15'h0007;
    check("in_ready low during DATA", in_ready, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    finishFrame("ignore");
    repeat (20) @(negedge clk);

    // Reset asserted mid-frame, during the length field.
    sendPkt(2'b00, 4'd0, 15'h0000, 32'h0, 7);
    repeat (3) @(posedge clk);
    #2;
    check("SerOut low before reset", SerOut, 0);
    rst = 1'b0;
    #1;
    check("async reset SerOut", SerOut, 1);
    check("async reset in_ready", in_ready, 1);
    check("async reset busy", busy, 0);
    sbQ.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    zeros = 0;
    repeat (20) begin
      @(negedge clk);
      if (!SerOut || busy) zeros++;
    end
    check("line idle after reset", zeros, 0);
    sendPkt(2'b11, 4'd4, 15'h0009, 32'h349, 11);
    finishFrame("post-reset");

    repeat (30) @(negedge clk);
    check("scoreboard drained", sbQ.size(), 0);
    check("frames seen", framesSeen, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
